// File: rtl/simon_autoplayer.sv
// simon_autoplayer: watches the Simon game's LED bus, buffers the one-hot
// symbols it shows, then replays them by toggling the matching switch bits.
module simon_autoplayer #(
   parameter int SEQ_LEN    = 8,
   parameter int IDX_W      = 3,
   parameter int HOLD_TICKS = 2,
   parameter int GAP_TICKS  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         tick,
   input  logic                         enable,
   input  logic [2**IDX_W-1:0]          led_in,
   output logic [2**IDX_W-1:0]          sw_out,
   output logic                         busy,
   output logic                         done,
   output logic                         error,
   output logic [$clog2(SEQ_LEN+1)-1:0] sym_count
);

   localparam int W      = 2**IDX_W;
   localparam int CNT_W  = $clog2(SEQ_LEN+1);
   localparam int ADDR_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
   localparam int GAP_W  = $clog2(GAP_TICKS+1);
   localparam int HOLD_W = $clog2(HOLD_TICKS+1);

   localparam logic [CNT_W-1:0]  SEQ_FULL = CNT_W'(SEQ_LEN);
   localparam logic [GAP_W-1:0]  GAP_END  = GAP_W'(GAP_TICKS);
   localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(HOLD_TICKS);

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_REPLAY, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    count_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [CNT_W-1:0]    ptr_q, ptr_d;
   logic [W-1:0]        sw_d;
   logic                error_d;
   logic                busy_d, done_d;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [IDX_W-1:0]    seq_buf [SEQ_LEN];
   logic [IDX_W-1:0]    rd_idx;

   logic                led_zero, led_multi;
   logic [IDX_W-1:0]    led_idx;

   // Decode the LED bus: gap, multi-hot, and the index of the lit bit.
   always_comb begin
      led_idx = '0;
      for (int i = 0; i < W; i++) begin
         if (led_in[i]) led_idx = IDX_W'(i);
      end
   end

   assign led_zero  = (led_in == '0);
   assign led_multi = ((led_in & (led_in - W'(1))) != '0);
   assign rd_idx    = seq_buf[ptr_q[ADDR_W-1:0]];

   // Next-state and next-output logic; abort on enable low beats any tick.
   always_comb begin
      // NOTE: every variable gets a default here so no path can infer a latch.
      state_d = state_q;
      count_d = sym_count;
      gap_d   = gap_q;
      hold_d  = hold_q;
      ptr_d   = ptr_q;
      sw_d    = sw_out;
      error_d = error;
      wr_en   = 1'b0;
      wr_addr = '0;
      if (!enable) begin
         state_d = S_IDLE;
         count_d = '0;
      end else if (tick) begin
         unique case (state_q)
            S_IDLE: begin
               if (led_multi) begin
                  error_d = 1'b1;
               end else if (!led_zero) begin
                  wr_en   = 1'b1;
                  count_d = CNT_W'(1);
                  gap_d   = '0;
                  state_d = S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (led_multi) begin
                  error_d = 1'b1;
               end else if (!led_zero) begin
                  if (sym_count < SEQ_FULL) begin
                     wr_en   = 1'b1;
                     wr_addr = sym_count[ADDR_W-1:0];
                     count_d = sym_count + CNT_W'(1);
                     gap_d   = '0;
                  end else begin
                     error_d = 1'b1;
                  end
               end else begin
                  gap_d = gap_q + GAP_W'(1);
               end
               if (led_zero && (sym_count == SEQ_FULL || gap_d == GAP_END)) begin
                  state_d = S_REPLAY;
                  ptr_d   = '0;
                  hold_d  = '0;
               end
            end
            S_REPLAY: begin
               hold_d = hold_q + HOLD_W'(1);
               if (hold_d == HOLD_END) begin
                  sw_d   = sw_out ^ (W'(1) << rd_idx);
                  ptr_d  = ptr_q + CNT_W'(1);
                  hold_d = '0;
                  if (ptr_d == sym_count) state_d = S_DONE;
               end
            end
            S_DONE: begin
               state_d = S_DONE;
            end
         endcase
      end
      busy_d = (state_d == S_CAPTURE) || (state_d == S_REPLAY);
      done_d = (state_d == S_DONE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q   <= S_IDLE;
         sym_count <= '0;
         gap_q     <= '0;
         hold_q    <= '0;
         ptr_q     <= '0;
         sw_out    <= '0;
         error     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         sym_count <= count_d;
         gap_q     <= gap_d;
         hold_q    <= hold_d;
         ptr_q     <= ptr_d;
         sw_out    <= sw_d;
         error     <= error_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

   // Symbol buffer write port.
   always_ff @(posedge clk) begin
      // NOTE: the buffer has no reset; sym_count gates which slots are ever read.
      if (wr_en) seq_buf[wr_addr] <= led_idx;
   end

endmodule

// File: tb/tb_simon_autoplayer.sv
// tb_simon_autoplayer: scoreboard bench; a tick-level reference model predicts
// each switch toggle and the final status, a monitor compares them as they appear.
module tb_simon_autoplayer;

   localparam int SEQ_LEN    = 8;
   localparam int IDX_W      = 3;
   localparam int HOLD_TICKS = 2;
   localparam int GAP_TICKS  = 4;
   localparam int W          = 2**IDX_W;
   localparam int CNT_W      = $clog2(SEQ_LEN+1);

   logic             clk = 1'b0;
   logic             rst, tick, enable;
   logic [W-1:0]     led_in, sw_out;
   logic             busy, done, error;
   logic [CNT_W-1:0] sym_count;

   simon_autoplayer #(
      .SEQ_LEN(SEQ_LEN), .IDX_W(IDX_W), .HOLD_TICKS(HOLD_TICKS), .GAP_TICKS(GAP_TICKS)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick), .enable(enable), .led_in(led_in),
      .sw_out(sw_out), .busy(busy), .done(done), .error(error), .sym_count(sym_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, actual, actual, expected, expected, $time);
      end
   endtask

   typedef enum {EV_TOGGLE, EV_DONE} ev_kind_t;
   typedef struct {
      ev_kind_t kind;
      int       t;
      int       sw;
      int       cnt;
      int       err;
   } ev_t;

   ev_t exp_q[$];

   // Tick bookkeeping seen by the monitor: number of ticks consumed so far.
   int tick_no   = 0;
   bit last_tick = 1'b0;
   always @(posedge clk) begin
      last_tick = (tick === 1'b1);
      if (tick === 1'b1) tick_no++;
   end

   // Monitor: every sw_out change and every rising done pops one expectation.
   bit           mon_on = 1'b0;
   logic [W-1:0] prev_sw = '0;
   logic         prev_done = 1'b0;
   always @(negedge clk) begin
      ev_t e;
      int  cur_t;
      cur_t = last_tick ? tick_no : -1;
      if (mon_on) begin
         if (sw_out !== prev_sw) begin
            if (exp_q.size() == 0 || exp_q[0].kind != EV_TOGGLE) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_toggle: sw_out=0x%0h, no toggle expected at %0t", sw_out, $time);
            end else begin
               e = exp_q.pop_front();
               check("toggle_sw", sw_out, e.sw);
               check("toggle_tick", cur_t, e.t);
            end
         end
         if (done === 1'b1 && prev_done !== 1'b1) begin
            if (exp_q.size() == 0 || exp_q[0].kind != EV_DONE) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_done: done rose with no completion expected at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               check("done_tick", cur_t, e.t);
               check("done_sw", sw_out, e.sw);
               check("done_count", sym_count, e.cnt);
               check("done_error", error, e.err);
               check("done_busy", busy, 0);
            end
         end
      end
      prev_sw   = sw_out;
      prev_done = done;
   end

   function automatic logic [W-1:0] oh(input int i);
      logic [W-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic int idx_of(input logic [W-1:0] v);
      for (int i = 0; i < W; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Reference model: walk the tick-by-tick LED samples, collect the captured
   // symbols, the error flag and the tick on which replay begins.
   task automatic model(input logic [W-1:0] leds[$], output int syms[$],
                        output int err, output int entry);
      int           gap;
      bit           capturing;
      logic [W-1:0] v;
      syms = {};
      err = 0;
      entry = -1;
      gap = 0;
      capturing = 1'b0;
      for (int t = 1; t <= leds.size() + GAP_TICKS + 1 && entry < 0; t++) begin
         v = (t <= leds.size()) ? leds[t-1] : '0;
         if ($countones(v) > 1) begin
            err = 1;
         end else if ($countones(v) == 1) begin
            if (!capturing) begin
               capturing = 1'b1;
               syms.push_back(idx_of(v));
               gap = 0;
            end else if (syms.size() < SEQ_LEN) begin
               syms.push_back(idx_of(v));
               gap = 0;
            end else begin
               err = 1;
            end
         end else if (capturing) begin
            gap++;
            if (syms.size() == SEQ_LEN || gap == GAP_TICKS) entry = t;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_sw_out"}, sw_out, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_error"}, error, 0);
      check({tag, "_sym_count"}, sym_count, 0);
   endtask

   task automatic do_reset();
      mon_on = 1'b0;
      rst    = 1'b1;
      tick   = 1'b0;
      led_in = '0;
      step();
      check_reset_values("reset");
      rst = 1'b0;
      exp_q.delete();
      tick_no = 0;
      step();
      mon_on = 1'b1;
   endtask

   // One game: predict, reset, then feed one LED sample per tick.
   // abort >= 0 drops enable on the tick that would make toggle abort+1.
   task automatic run_game(input string tag, input logic [W-1:0] leds[$],
                           input int period, input int abort);
      int           syms[$];
      int           err, entry, sw, last_t, n;
      logic [W-1:0] v;
      model(leds, syms, err, entry);
      n = syms.size();
      do_reset();
      sw = 0;
      for (int k = 1; k <= n; k++) begin
         sw = sw ^ (1 << syms[k-1]);
         if (abort < 0 || k <= abort)
            exp_q.push_back('{EV_TOGGLE, entry + HOLD_TICKS*k, sw, 0, 0});
      end
      if (abort < 0) begin
         exp_q.push_back('{EV_DONE, entry + HOLD_TICKS*n, sw, n, err});
         last_t = entry + HOLD_TICKS*n;
      end else begin
         sw = 0;
         for (int k = 1; k <= abort; k++) sw = sw ^ (1 << syms[k-1]);
         last_t = entry + HOLD_TICKS*(abort + 1);
      end
      enable = 1'b1;
      for (int t = 1; t <= last_t; t++) begin
         v = (t <= leds.size()) ? leds[t-1] : '0;
         for (int p = 1; p < period; p++) begin
            tick = 1'b0;
            led_in = v;
            step();
         end
         tick = 1'b1;
         led_in = v;
         if (abort >= 0 && t == last_t) enable = 1'b0;
         step();
      end
      tick = 1'b0;
      if (abort >= 0) begin
         check({tag, "_abort_busy"}, busy, 0);
         check({tag, "_abort_done"}, done, 0);
         check({tag, "_abort_sw"}, sw_out, sw);
         check({tag, "_abort_count"}, sym_count, 0);
         check({tag, "_abort_error"}, error, err);
      end
      repeat (3) step();
      check({tag, "_pending_events"}, exp_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] q[$];
      logic [W-1:0] mh;
      int           a, n_sym;
      rst = 1'b1; tick = 1'b0; enable = 1'b0; led_in = '0;
      step();

      // Full eight-symbol game, repeated symbol 5 returns its switch.
      q = {oh(5), oh(3), oh(6), oh(7), oh(4), oh(1), oh(2), oh(5)};
      run_game("full", q, 1, -1);

      // Short game ended by a run of gap ticks.
      q = {oh(1), oh(2), oh(4)};
      run_game("gap_exit", q, 1, -1);

      // Multi-hot sample in the middle is dropped and flags error.
      q = {oh(2), oh(6), 8'h24, oh(0), oh(3)};
      run_game("multi_hot", q, 1, -1);

      // Ninth consecutive symbol overflows.
      q = {oh(1), oh(2), oh(3), oh(4), oh(5), oh(6), oh(7), oh(0), oh(4)};
      run_game("overflow", q, 1, -1);

      // Same game with a slow tick.
      q = {oh(5), oh(3), oh(6), oh(7), oh(4), oh(1), oh(2), oh(5)};
      run_game("slow_tick", q, 4, -1);

      // Abort during replay after three toggles, exactly on a toggle tick.
      q = {oh(5), oh(3), oh(6), oh(7), oh(4), oh(1), oh(2), oh(5)};
      run_game("abort", q, 1, 3);

      // Sparse ticks from IDLE, then reset mid-capture while sw_out is nonzero.
      mon_on = 1'b0;
      enable = 1'b1;
      led_in = 8'h24;
      tick = 1'b0; step(); step(); step();
      tick = 1'b1; step();
      check("sparse_multi_error", error, 1);
      check("sparse_multi_idle", busy, 0);
      led_in = oh(1);
      tick = 1'b0; step();
      check("sparse_no_tick_idle", busy, 0);
      step(); step();
      check("sparse_no_tick_count", sym_count, 0);
      tick = 1'b1; step();
      check("sparse_capture_busy", busy, 1);
      check("sparse_capture_count", sym_count, 1);
      led_in = oh(3);
      tick = 1'b0; step();
      check("sparse_hold_count", sym_count, 1);
      tick = 1'b1; step();
      check("sparse_second_count", sym_count, 2);
      check("sparse_sw_kept", sw_out, 8'h68);
      tick = 1'b0;
      rst = 1'b1;
      step();
      check_reset_values("mid_capture_reset");
      rst = 1'b0;

      // Randomized games: leading gaps, short inner gaps, multi-hot noise.
      for (int r = 0; r < 16; r++) begin
         q = {};
         repeat ($urandom_range(0, 3)) q.push_back('0);
         n_sym = $urandom_range(1, 10);
         for (int i = 0; i < n_sym; i++) begin
            if ($urandom_range(0, 5) == 0) begin
               a = $urandom_range(0, W-1);
               mh = oh(a) | oh((a + 1 + $urandom_range(0, W-2)) % W);
               q.push_back(mh);
            end
            if (i > 0 && $urandom_range(0, 4) == 0)
               repeat ($urandom_range(1, GAP_TICKS-1)) q.push_back('0);
            q.push_back(oh($urandom_range(0, W-1)));
         end
         run_game("random", q, $urandom_range(1, 4), -1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
